// File: rtl/log_int_search.sv
// Integer part of ln(y) for an unsigned Q3.14 operand. The search walks an external
// e^k ROM from k=+2 down to k=-3 and stops at the first entry that does not exceed y.
module log_int_search (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iValid,
  output logic        oReady,
  input  logic [16:0] iData,
  output logic [2:0]  oRomAddr,
  input  logic [16:0] iRomData,
  output logic        oValid,
  input  logic        iReady,
  output logic [2:0]  oK,
  output logic [16:0] oBase,
  output logic [16:0] oDiff,
  output logic        oUnder
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] K_TOP    = 3'b010;  // +2
  localparam logic [2:0] K_BOTTOM = 3'b101;  // -3

  state_t      state_q, state_d;
  logic [16:0] y_q, y_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  k_q, k_d;
  logic [16:0] base_q, base_d;
  logic [16:0] diff_q, diff_d;
  logic        under_q, under_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      y_q     <= '0;
      addr_q  <= '0;
      k_q     <= '0;
      base_q  <= '0;
      diff_q  <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      base_q  <= base_d;
      diff_q  <= diff_d;
      under_q <= under_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    addr_d  = addr_q;
    k_d     = k_q;
    base_d  = base_q;
    diff_d  = diff_q;
    under_d = under_q;

    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          y_d     = iData;
          addr_d  = K_TOP;
          state_d = FETCH;
        end
      end

      // The ROM registers oRomAddr on this edge; its data is ready in CMP.
      FETCH: state_d = CMP;

      CMP: begin
        if (iRomData <= y_q) begin
          k_d     = addr_q;
          base_d  = iRomData;
          diff_d  = y_q - iRomData;
          under_d = 1'b0;
          state_d = DONE;
        end else if (addr_q == K_BOTTOM) begin
          // Below e^-3: clamp k and flag the underflow instead of searching further.
          k_d     = K_BOTTOM;
          base_d  = iRomData;
          diff_d  = '0;
          under_d = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = addr_q - 3'd1;
          state_d = FETCH;
        end
      end

      DONE: begin
        if (iReady) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign oReady   = (state_q == IDLE);
  assign oValid   = (state_q == DONE);
  assign oRomAddr = addr_q;
  assign oK       = k_q;
  assign oBase    = base_q;
  assign oDiff    = diff_q;
  assign oUnder   = under_q;

endmodule

// File: doc/log_int_search.md
LOG_INT_SEARCH -- requirements
Module: log_int_search

Interface
REQ-001 SHALL expose: CLK  input  1  rising-edge clock, sole clock.
REQ-002 SHALL expose: RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL expose: iValid  input  1  request valid.
REQ-004 SHALL expose: oReady  output  1  block can accept a request.
REQ-005 SHALL expose: iData  input  17  operand y, unsigned Q3.14.
REQ-006 SHALL expose: oRomAddr  output  3  registered address to exp ROM, signed k (3'b101=-3 .. 3'b010=+2).
REQ-007 SHALL expose: iRomData  input  17  ROM data e^k, Q3.14, valid one cycle after the address is sampled.
REQ-008 SHALL expose: oValid  output  1  result valid.
REQ-009 SHALL expose: iReady  input  1  downstream accepts result.
REQ-010 SHALL expose: oK  output  3  signed integer part floor(ln y), clamped to -3.
REQ-011 SHALL expose: oBase  output  17  e^oK as read from ROM.
REQ-012 SHALL expose: oDiff  output  17  y - oBase, unsigned; 0 when oUnder.
REQ-013 SHALL expose: oUnder  output  1  y < e^-3 (816).

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, CMP, DONE.
REQ-015 IDLE: oReady=1, oValid=0; on iValid&oReady capture y, set oRomAddr=3'b010, go to FETCH.
REQ-016 FETCH: one cycle for the ROM to sample oRomAddr; oReady=0; go to CMP.
REQ-017 CMP: compare iRomData <= y (17-bit unsigned); on true, latch oK=oRomAddr, oBase=iRomData, oDiff=y-iRomData, oUnder=0, go to DONE.
REQ-018 CMP false with oRomAddr=3'b101: latch oK=3'b101, oBase=iRomData, oDiff=0, oUnder=1, go to DONE.
REQ-019 CMP false otherwise: oRomAddr decrements modulo 8 (2,1,0,7,6,5), go to FETCH.
REQ-020 DONE: oValid=1, outputs held stable; on iValid... ignored; on iReady go to IDLE next cycle.
REQ-021 Latency: with acceptance at edge E0, after n comparisons oValid SHALL rise after edge E(2n); n=1..6, worst case 12 cycles.
REQ-022 y >= 121062 SHALL give oK=+2 (no overflow flag; 17-bit max < e^3).
REQ-023 y=0 SHALL give oUnder=1 after 6 comparisons.
REQ-024 iValid while oReady=0 SHALL be ignored; no queuing.
REQ-025 oK, oBase, oDiff, oUnder SHALL change only on the CMP->DONE transition.

Reset
REQ-026 RST at a clock edge SHALL force IDLE and oValid=0, oReady=1, oRomAddr=0, oK=0, oBase=0, oDiff=0, oUnder=0.
REQ-027 RST mid-search or in DONE SHALL discard the operation; no result SHALL be emitted.
REQ-028 RST SHALL take priority over iValid and iReady in the same cycle.

Verification (bench models the ROM: 1-cycle registered read, table -3:816, -2:2217, -1:6027, 0:16384, 1:44536, 2:121062)
REQ-029 y=131071, iReady=1 -> oK=010, oBase=121062, oDiff=10009, oUnder=0, oValid after E2.
REQ-030 y=16384 -> oK=000, oBase=16384, oDiff=0, oValid after E6; y=6026 -> oK=110, oBase=2217, oDiff=3809, after E10.
REQ-031 y=816 -> oK=101, oUnder=0, oDiff=0; y=500 -> oK=101, oBase=816, oDiff=0, oUnder=1, after E12.
REQ-032 iReady=0 for 5 cycles in DONE -> outputs stable, oReady=0, extra iValid pulses ignored; iReady=1 -> IDLE, oReady=1 next cycle.
REQ-033 RST asserted during FETCH of the third comparison -> next cycle IDLE, all outputs at reset values, no oValid pulse; a new request then completes normally.
REQ-034 Back-to-back requests with iReady tied high -> every result matches a reference floor(ln y) model, one result per request.
